// File: rtl/dtcore32_pkg.sv
// Shared types for the dtcore32 pipeline controller: forwarding selects and
// data-memory wait states.
package dtcore32_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } dmem_state_e;

  // The MEM result is younger than WB, so it wins when both match.
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/dtcore32_dmem_wait_fsm.sv
// Variable-latency data-memory wait FSM with timeout and drain of a response
// orphaned by a trap. mem_stall_o is raw; the caller applies the WB-trap override.
module dtcore32_dmem_wait_fsm
  import dtcore32_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic rvalid_i,
  input  logic wb_trap_i,
  output logic mem_stall_o,
  output logic dmem_fault_o
);

  localparam int TO_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

  dmem_state_e       r_state;
  dmem_state_e       w_next;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_timeout;

  assign w_timeout = (DMEM_TIMEOUT != 0) && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_next;
      // Held at zero outside WAIT, so it is already clear on entry.
      r_to_cnt <= (r_state == WAIT) ? r_to_cnt + TO_W'(1) : '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_stall_o  = 1'b0;
    dmem_fault_o = 1'b0;
    case (r_state)
      IDLE: begin
        mem_stall_o = req_i;
        if (req_i && !wb_trap_i) w_next = IDLE == IDLE ? WAIT : IDLE;
      end
      WAIT: begin
        mem_stall_o = !rvalid_i;
        if (rvalid_i) begin
          w_next = IDLE;
        end else if (wb_trap_i) begin
          w_next = DRAIN;
        end else if (w_timeout) begin
          w_next       = IDLE;
          dmem_fault_o = 1'b1;
        end
      end
      DRAIN: begin
        // The response still in flight belongs to a squashed access; hold any
        // new request until it has been swallowed.
        mem_stall_o = req_i;
        if (rvalid_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: rtl/dtcore32_pipe_ctrl.sv
// dtcore32 hazard/forwarding controller: forwarding selects, load-use and
// data-memory stalls, per-stage flushes. Optional stall counters: DTCORE32_STALL_CNT_EN.
module dtcore32_pipe_ctrl
  import dtcore32_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] ID_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] ID_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] EX_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] EX_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] EX_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] MEM_rd_addr_i,
  input  logic [REG_ADDR_W-1:0] WB_rd_addr_i,
  input  logic                  MEM_reg_wr_en_i,
  input  logic                  WB_reg_wr_en_i,
  input  logic                  EX_load_i,
  input  logic                  MEM_dmem_req_i,
  input  logic                  dmem_rvalid_i,
  input  logic                  EX_pc_src_i,
  input  logic                  ID_trap_valid_i,
  input  logic                  EX_trap_valid_i,
  input  logic                  MEM_trap_valid_i,
  input  logic                  WB_trap_valid_i,
  output logic [1:0]            EX_forward_a_o,
  output logic [1:0]            EX_forward_b_o,
  output logic                  ID_forward_a_o,
  output logic                  ID_forward_b_o,
  output logic                  IF_stall_o,
  output logic                  ID_stall_o,
  output logic                  EX_stall_o,
  output logic                  MEM_stall_o,
  output logic                  ID_flush_o,
  output logic                  EX_flush_o,
  output logic                  MEM_flush_o,
  output logic                  WB_flush_o,
  output logic                  dmem_fault_o,
  output logic [CNT_W-1:0]      stall_cnt_lu_o,
  output logic [CNT_W-1:0]      stall_cnt_mem_o
);

  logic w_load_use;
  logic w_mem_stall_raw;
  logic w_mem_stall;
  logic w_fault;
  logic w_wb_trap;
  logic w_redirect;

  assign w_wb_trap = WB_trap_valid_i;

  assign EX_forward_a_o = fwd_select(
      (EX_rs1_addr_i != '0) && MEM_reg_wr_en_i && (EX_rs1_addr_i == MEM_rd_addr_i),
      (EX_rs1_addr_i != '0) && WB_reg_wr_en_i  && (EX_rs1_addr_i == WB_rd_addr_i));
  assign EX_forward_b_o = fwd_select(
      (EX_rs2_addr_i != '0) && MEM_reg_wr_en_i && (EX_rs2_addr_i == MEM_rd_addr_i),
      (EX_rs2_addr_i != '0) && WB_reg_wr_en_i  && (EX_rs2_addr_i == WB_rd_addr_i));

  assign ID_forward_a_o = (ID_rs1_addr_i != '0) && WB_reg_wr_en_i && (ID_rs1_addr_i == WB_rd_addr_i);
  assign ID_forward_b_o = (ID_rs2_addr_i != '0) && WB_reg_wr_en_i && (ID_rs2_addr_i == WB_rd_addr_i);

  // A taken branch in EX squashes the dependent instruction anyway.
  assign w_load_use = EX_load_i && (EX_rd_addr_i != '0) && !EX_pc_src_i &&
                      ((ID_rs1_addr_i == EX_rd_addr_i) || (ID_rs2_addr_i == EX_rd_addr_i));

  dtcore32_dmem_wait_fsm #(
    .DMEM_TIMEOUT (DMEM_TIMEOUT)
  ) u_dmem_wait (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (MEM_dmem_req_i),
    .rvalid_i     (dmem_rvalid_i),
    .wb_trap_i    (w_wb_trap),
    .mem_stall_o  (w_mem_stall_raw),
    .dmem_fault_o (w_fault)
  );

  assign w_mem_stall  = w_mem_stall_raw && !w_wb_trap;
  assign dmem_fault_o = w_fault;

  assign IF_stall_o  = (w_load_use || w_mem_stall) && !w_wb_trap;
  assign ID_stall_o  = IF_stall_o;
  assign EX_stall_o  = w_mem_stall;
  assign MEM_stall_o = w_mem_stall;

  assign w_redirect  = MEM_trap_valid_i || EX_trap_valid_i || EX_pc_src_i || w_fault;

  assign WB_flush_o  = w_wb_trap;
  assign MEM_flush_o = w_wb_trap || (MEM_trap_valid_i && !w_mem_stall) || w_fault;
  assign EX_flush_o  = w_wb_trap || ((w_redirect || w_load_use) && !w_mem_stall);
  assign ID_flush_o  = w_wb_trap ||
                       ((w_redirect || (ID_trap_valid_i && !w_load_use)) && !w_mem_stall);

`ifdef DTCORE32_STALL_CNT_EN
  logic [CNT_W-1:0] r_cnt_lu;
  logic [CNT_W-1:0] r_cnt_mem;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt_lu  <= '0;
      r_cnt_mem <= '0;
    end else begin
      if (w_load_use && !w_wb_trap) r_cnt_lu  <= r_cnt_lu + CNT_W'(1);
      if (w_mem_stall)              r_cnt_mem <= r_cnt_mem + CNT_W'(1);
    end
  end

  assign stall_cnt_lu_o  = r_cnt_lu;
  assign stall_cnt_mem_o = r_cnt_mem;
`else
  assign stall_cnt_lu_o  = '0;
  assign stall_cnt_mem_o = '0;
`endif

endmodule

// File: tb/tb_dtcore32_pipe_ctrl.sv
// Self-checking bench for dtcore32_pipe_ctrl: directed scenarios then random
// traffic, checked against a flag-based memory-transaction model.
module tb_dtcore32_pipe_ctrl;

  localparam int RW = 5;
  localparam int TO = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic mem_we, wb_we, ex_load, mem_req, rvalid, ex_pc_src;
  logic id_trap, ex_trap, mem_trap, wb_trap;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  logic id_fwd_a, id_fwd_b;
  logic if_stall, id_stall, ex_stall, mem_stall;
  logic id_flush, ex_flush, mem_flush, wb_flush;
  logic fault;
  logic [CW-1:0] cnt_lu, cnt_mem;

  always #5 clk = ~clk;

  dtcore32_pipe_ctrl #(
    .REG_ADDR_W   (RW),
    .DMEM_TIMEOUT (TO),
    .CNT_W        (CW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ID_rs1_addr_i    (id_rs1),
    .ID_rs2_addr_i    (id_rs2),
    .EX_rs1_addr_i    (ex_rs1),
    .EX_rs2_addr_i    (ex_rs2),
    .EX_rd_addr_i     (ex_rd),
    .MEM_rd_addr_i    (mem_rd),
    .WB_rd_addr_i     (wb_rd),
    .MEM_reg_wr_en_i  (mem_we),
    .WB_reg_wr_en_i   (wb_we),
    .EX_load_i        (ex_load),
    .MEM_dmem_req_i   (mem_req),
    .dmem_rvalid_i    (rvalid),
    .EX_pc_src_i      (ex_pc_src),
    .ID_trap_valid_i  (id_trap),
    .EX_trap_valid_i  (ex_trap),
    .MEM_trap_valid_i (mem_trap),
    .WB_trap_valid_i  (wb_trap),
    .EX_forward_a_o   (ex_fwd_a),
    .EX_forward_b_o   (ex_fwd_b),
    .ID_forward_a_o   (id_fwd_a),
    .ID_forward_b_o   (id_fwd_b),
    .IF_stall_o       (if_stall),
    .ID_stall_o       (id_stall),
    .EX_stall_o       (ex_stall),
    .MEM_stall_o      (mem_stall),
    .ID_flush_o       (id_flush),
    .EX_flush_o       (ex_flush),
    .MEM_flush_o      (mem_flush),
    .WB_flush_o       (wb_flush),
    .dmem_fault_o     (fault),
    .stall_cnt_lu_o   (cnt_lu),
    .stall_cnt_mem_o  (cnt_mem)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Memory transaction model: an access is outstanding (busy) or a squashed
  // access still owes a response (drain); age counts completed wait cycles.
  bit m_busy, m_drain;
  int m_age, m_cnt_lu, m_cnt_mem;

  // Snapshots of DUT outputs taken at the last sampling point.
  logic o_stall, o_fault, o_mflush, o_all_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_ex_fwd(input logic [RW-1:0] rs);
    if (rs != 0 && mem_we && rs == mem_rd) return 2;
    if (rs != 0 && wb_we && rs == wb_rd)   return 1;
    return 0;
  endfunction

  function automatic int exp_id_fwd(input logic [RW-1:0] rs);
    return (rs != 0 && wb_we && rs == wb_rd) ? 1 : 0;
  endfunction

  task automatic set_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    mem_we = 0; wb_we = 0; ex_load = 0; mem_req = 0; rvalid = 0; ex_pc_src = 0;
    id_trap = 0; ex_trap = 0; mem_trap = 0; wb_trap = 0;
  endtask

  // One clock: check every output against the model mid-cycle, then advance
  // the model on the rising edge.
  task automatic step();
    bit lu, raw, ms, flt, wb, e_if, e_ex, e_mem, e_id;
    @(negedge clk);
    wb  = wb_trap;
    lu  = ex_load && ex_rd != 0 && (id_rs1 == ex_rd || id_rs2 == ex_rd) && !ex_pc_src;
    if (m_drain)     raw = mem_req;
    else if (m_busy) raw = !rvalid;
    else             raw = mem_req;
    ms  = raw && !wb;
    flt = m_busy && !m_drain && !rvalid && !wb && (m_age == TO - 1);
    e_if  = (lu || ms) && !wb;
    e_mem = wb || (mem_trap && !ms) || flt;
    e_ex  = wb || ((mem_trap || ex_trap || ex_pc_src || lu || flt) && !ms);
    e_id  = wb || ((mem_trap || ex_trap || ex_pc_src || flt || (id_trap && !lu)) && !ms);

    check("ex_fwd_a", 32'(ex_fwd_a), exp_ex_fwd(ex_rs1));
    check("ex_fwd_b", 32'(ex_fwd_b), exp_ex_fwd(ex_rs2));
    check("id_fwd_a", 32'(id_fwd_a), exp_id_fwd(id_rs1));
    check("id_fwd_b", 32'(id_fwd_b), exp_id_fwd(id_rs2));
    check("if_stall", 32'(if_stall), 32'(e_if));
    check("id_stall", 32'(id_stall), 32'(e_if));
    check("ex_stall", 32'(ex_stall), 32'(ms));
    check("mem_stall", 32'(mem_stall), 32'(ms));
    check("wb_flush", 32'(wb_flush), 32'(wb));
    check("mem_flush", 32'(mem_flush), 32'(e_mem));
    check("ex_flush", 32'(ex_flush), 32'(e_ex));
    check("id_flush", 32'(id_flush), 32'(e_id));
    check("dmem_fault", 32'(fault), 32'(flt));
`ifdef DTCORE32_STALL_CNT_EN
    check("cnt_lu", 32'(cnt_lu), m_cnt_lu);
    check("cnt_mem", 32'(cnt_mem), m_cnt_mem);
`else
    check("cnt_lu", 32'(cnt_lu), 0);
    check("cnt_mem", 32'(cnt_mem), 0);
`endif
    o_stall     = mem_stall;
    o_fault     = fault;
    o_mflush    = mem_flush;
    o_all_flush = id_flush & ex_flush & mem_flush & wb_flush;

    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_drain = 0; m_age = 0; m_cnt_lu = 0; m_cnt_mem = 0;
    end else begin
      if (lu && !wb) m_cnt_lu  = (m_cnt_lu + 1) % (1 << CW);
      if (ms)        m_cnt_mem = (m_cnt_mem + 1) % (1 << CW);
      if (m_drain) begin
        if (rvalid) m_drain = 0;
      end else if (m_busy) begin
        if (rvalid)   m_busy = 0;
        else if (wb)  begin m_busy = 0; m_drain = 1; end
        else if (flt) m_busy = 0;
        else          m_age++;
      end else if (mem_req && !wb) begin
        m_busy = 1;
        m_age  = 0;
      end
    end
    #1;
  endtask

  initial begin
    int stalls, fstep, nflt;
    logic fmf;
    set_idle();
    rst = 1;
    m_busy = 0; m_drain = 0; m_age = 0; m_cnt_lu = 0; m_cnt_mem = 0;
    @(posedge clk); #1;
    step();
    rst = 0;
    step();
    check("rst_no_stall", 32'(o_stall), 0);
    check("rst_no_fault", 32'(o_fault), 0);

    // Forwarding priority and x0 suppression
    ex_rs1 = 5; mem_rd = 5; mem_we = 1; wb_rd = 5; wb_we = 1; id_rs1 = 5;
    step();
    check("fwd_a_mem_pri", 32'(ex_fwd_a), 2);
    check("id_fwd_a_wb", 32'(id_fwd_a), 1);
    mem_we = 0; step();
    check("fwd_a_wb", 32'(ex_fwd_a), 1);
    ex_rs1 = 0; mem_we = 1; step();
    check("fwd_a_x0", 32'(ex_fwd_a), 0);

    // Load-use hazard, then the same hazard under a taken branch
    set_idle(); ex_load = 1; ex_rd = 7; id_rs2 = 7;
    step();
    check("lu_if_stall", 32'(if_stall), 1);
    check("lu_ex_flush", 32'(ex_flush), 1);
    ex_load = 0; step();
    check("lu_released", 32'(if_stall), 0);
    ex_load = 1; ex_pc_src = 1; step();
    check("lu_branch_no_stall", 32'(if_stall), 0);

    // Memory access answered on the third wait cycle
    begin
`ifdef DTCORE32_STALL_CNT_EN
      logic [CW-1:0] c0, d;
      c0 = cnt_mem;
`endif
      set_idle(); mem_req = 1; stalls = 0;
      for (int i = 0; i < 4; i++) begin
        rvalid = (i == 3);
        step();
        stalls += int'(o_stall);
      end
      check("wait3_stall_cycles", stalls, 3);
      check("wait3_release", 32'(o_stall), 0);
      mem_req = 0; rvalid = 0; step();
      check("wait3_idle", 32'(o_stall), 0);
`ifdef DTCORE32_STALL_CNT_EN
      d = cnt_mem - c0;
      check("wait3_cnt_mem", 32'(d), 3);
`endif
    end

    // Timeout with no response
    set_idle(); mem_req = 1; fstep = -1; nflt = 0; fmf = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_fault) begin nflt++; fstep = i; fmf = o_mflush; end
    end
    check("to_fault_cycle", fstep, 4);
    check("to_single_pulse", nflt, 1);
    check("to_mem_flush", 32'(fmf), 1);
    mem_req = 0; step();
    check("to_back_idle", 32'(o_stall), 0);

    // Trap while waiting: drain the orphaned response, then reissue
    set_idle(); mem_req = 1; step(); step();
    wb_trap = 1; step();
    check("trap_flush_all", 32'(o_all_flush), 1);
    check("trap_no_stall", 32'(o_stall), 0);
    wb_trap = 0; step();
    check("drain_hold", 32'(o_stall), 1);
    rvalid = 1; step();
    check("drain_discard", 32'(o_stall), 1);
    rvalid = 0; step();
    check("reissue_stall", 32'(o_stall), 1);
    rvalid = 1; step();
    check("reissue_done", 32'(o_stall), 0);

    // Trap and response in the same wait cycle return straight to idle
    set_idle(); mem_req = 1; step();
    wb_trap = 1; rvalid = 1; step();
    wb_trap = 0; rvalid = 0; step();
    rvalid = 1; step();
    check("trap_rvalid_idle", 32'(o_stall), 0);

    // Reset in the middle of a wait
    set_idle(); mem_req = 1; step(); step();
    rst = 1; step();
    rst = 0; rvalid = 1; step();
    check("rst_mid_wait_idle", 32'(o_stall), 1);

    // Random traffic
    set_idle();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      id_rs1    = RW'($urandom_range(0, 3));
      id_rs2    = RW'($urandom_range(0, 3));
      ex_rs1    = RW'($urandom_range(0, 3));
      ex_rs2    = RW'($urandom_range(0, 3));
      ex_rd     = RW'($urandom_range(0, 3));
      mem_rd    = RW'($urandom_range(0, 3));
      wb_rd     = RW'($urandom_range(0, 3));
      mem_we    = ($urandom_range(0, 1) == 1);
      wb_we     = ($urandom_range(0, 1) == 1);
      ex_load   = ($urandom_range(0, 2) == 0);
      mem_req   = ($urandom_range(0, 2) != 0);
      rvalid    = ($urandom_range(0, 4) == 0);
      ex_pc_src = ($urandom_range(0, 7) == 0);
      id_trap   = ($urandom_range(0, 9) == 0);
      ex_trap   = ($urandom_range(0, 9) == 0);
      mem_trap  = ($urandom_range(0, 9) == 0);
      wb_trap   = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
